// File: rtl/dbu_run_ctrl_pkg.sv
// Shared types and defaults for the debug-unit run controller.
// Pure declarations: no logic, no latency, no flow control.
package dbu_pkg;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        HOLD = 2'd3
    } run_state_t;

    localparam int ADDR_W_DEF          = 8;
    localparam int DEBOUNCE_CYCLES_DEF = 4;

endpackage

// File: rtl/dbu_run_ctrl_if.sv
// Operator controls in, CPU enable / inspection address / status out.
// Level signals only: no handshake and no backpressure on any member.
interface dbu_run_ctrl_if #(parameter int ADDR_W = 8);

    logic              succ;
    logic              step;
    logic              inc;
    logic              dec;
    logic              m_rf;
    logic              cpu_run;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       run_cnt;
    logic [1:0]        state;

    modport master (
        output succ, step, inc, dec, m_rf,
        input  cpu_run, addr, run_cnt, state
    );

    modport slave (
        input  succ, step, inc, dec, m_rf,
        output cpu_run, addr, run_cnt, state
    );

endinterface

// File: rtl/dbu_run_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop sync, stability counter, one-cycle rise pulse.
// Level/rise lag the pin by 2 + DEBOUNCE_CYCLES edges; no backpressure.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // The flip happens on the DEBOUNCE_CYCLES-th consecutive differing cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            rise  <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt   <= '0;
                level <= sync2;
                rise  <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/dbu_run_ctrl.sv
// Run/step FSM, inspection address counter and run-cycle counter for the DBU.
// succ -> cpu_run in 3 cycles, step -> pulse in 3 + DEBOUNCE_CYCLES; no backpressure.
module dbu_run_ctrl
    import dbu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int ADDR_W          = ADDR_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    dbu_run_ctrl_if.slave ctl
);

    logic              succ_s1, succ_s;
    logic              m_rf_s1, m_rf_s, m_rf_q;
    logic              step_lvl, step_rise;
    logic              inc_lvl, inc_rise;
    logic              dec_lvl, dec_rise;
    logic              inc_hit, dec_hit, m_rf_chg;
    run_state_t        state_q, state_d;
    logic              cpu_run_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       run_cnt_q;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
        .clk(clk), .rst(rst), .btn(ctl.step), .level(step_lvl), .rise(step_rise)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .clk(clk), .rst(rst), .btn(ctl.inc), .level(inc_lvl), .rise(inc_rise)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
        .clk(clk), .rst(rst), .btn(ctl.dec), .level(dec_lvl), .rise(dec_rise)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            succ_s1 <= 1'b0;
            succ_s  <= 1'b0;
            m_rf_s1 <= 1'b0;
            m_rf_s  <= 1'b0;
            m_rf_q  <= 1'b0;
        end else begin
            succ_s1 <= ctl.succ;
            succ_s  <= succ_s1;
            m_rf_s1 <= ctl.m_rf;
            m_rf_s  <= m_rf_s1;
            m_rf_q  <= m_rf_s;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HALT: begin
                if (succ_s)         state_d = RUN;
                else if (step_rise) state_d = STEP;
            end
            RUN: begin
                if (!succ_s) state_d = HALT;
            end
            STEP: state_d = HOLD;
            // Wait for release so a held button cannot retrigger.
            HOLD: begin
                if (succ_s)         state_d = RUN;
                else if (!step_lvl) state_d = HALT;
            end
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= HALT;
            cpu_run_q <= 1'b0;
            run_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cpu_run_q <= (state_d == RUN) || (state_d == STEP);
            if (cpu_run_q) run_cnt_q <= run_cnt_q + 16'd1;
        end
    end

    // A rise pulse always coincides with its new level being high.
    assign inc_hit  = inc_rise & inc_lvl & ~dec_rise;
    assign dec_hit  = dec_rise & dec_lvl & ~inc_rise;
    assign m_rf_chg = m_rf_s ^ m_rf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
        end else if (m_rf_chg) begin
            addr_q <= '0;
        end else if (inc_hit) begin
            addr_q <= addr_q + ADDR_W'(1);
        end else if (dec_hit) begin
            addr_q <= addr_q - ADDR_W'(1);
        end
    end

    assign ctl.cpu_run = cpu_run_q;
    assign ctl.addr    = addr_q;
    assign ctl.run_cnt = run_cnt_q;
    assign ctl.state   = state_q;

endmodule
